io_seg7_scan: RTL and testbench
===============================

# io_seg7_scan

Multiplexed seven-segment display scanner that sits directly downstream of the memory-mapped PIO output registers. The PIO group registers hold hex nibbles, decimal-point bits and digit enables. This block consumes them as static levels and time-multiplexes one digit at a time onto the shared segment and anode pins. It snapshots its inputs once per frame, so a CPU write never tears a frame, and it inserts an anti-ghosting blank at the start of each digit slot.

## Interface
- DIGITS, 8: number of digits scanned; legal range 1..16.
- PRESCALE, 50000: clk cycles per digit slot; must be ≥ 2.
- BLANK, 64: cycles at the start of each slot with all anodes off; must satisfy 0 ≤ BLANK < PRESCALE.
- ACTIVE_LOW, 1: 1 inverts seg, seg_dp and an at the pins; 0 drives them active-high.

- clk  input  1  system clock
- resetn  input  1  asynchronous, active-low reset
- value  input  4*DIGITS  hex nibble per digit; digit i = value[4i+3:4i]
- dp  input  DIGITS  decimal point per digit
- digit_en  input  DIGITS  per-digit enable; 0 keeps that anode off
- seg  output  7  segments; bit0 = a … bit6 = g
- seg_dp  output  1  decimal-point segment
- an  output  DIGITS  anode/common select, one-hot when active
- frame_start  output  1  one-cycle pulse when a new snapshot takes effect

## Operation
- Prescale counter `cnt` runs 0..PRESCALE-1 and wraps. Digit index `idx` runs 0..DIGITS-1; it increments when `cnt` wraps and wraps 0 after DIGITS-1.
- Load strobe fires when cnt == PRESCALE-1 and idx == DIGITS-1. On that edge, the shadow registers capture value, dp and digit_en.
- Each slot has two phases:
  - BLANK phase, cnt < BLANK: an all inactive, seg/seg_dp inactive.
  - DRIVE phase, cnt ≥ BLANK: an[idx] is active only if shadow digit_en[idx] = 1. seg = hex decode of shadow nibble idx. seg_dp = shadow dp[idx].
- If the enable for the current digit is 0, an, seg and seg_dp are all inactive.
- Hex decode, active-high a..g as a 7-bit value: 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F, A→77, b→7C, C→39, d→5E, E→79, F→71.
- ACTIVE_LOW = 1 inverts seg, seg_dp and an after decode. The inactive level is then all ones.
- Input changes between load strobes have no visible effect.

## Timing
- Reset (async, immediate), with outputs at the inactive level for the chosen polarity:
  - cnt = 0, idx = 0, shadow value/dp/digit_en = 0.
  - seg, seg_dp and an at the inactive level.
  - frame_start = 0.
- Consequence of reset: the first frame after reset is fully dark, because shadow digit_en = 0. Displayed data appears from the second frame onward.
- Outputs are registered, with 1-cycle latency from (cnt, idx, shadow) state.
  - For digit i, an[i] is active on the cycles after cnt reaches BLANK through the cycle after cnt reaches PRESCALE-1.
  - That gives PRESCALE-BLANK active cycles and BLANK dark cycles per slot.
- frame_start is registered from the load strobe. It is high on the same cycle that slot 0 of the new frame enters its output register, once every DIGITS*PRESCALE cycles.
- Frame period is exactly DIGITS*PRESCALE cycles. There are no gaps between slots.
- At most one anode is active in any cycle, and never across a slot boundary.
- Reset asserted mid-frame:
  - Outputs go inactive asynchronously and the shadow is cleared.
  - After release, the scan restarts at idx 0, cnt 0 with a dark first frame.
- DIGITS = 1: idx stays 0, and the load strobe fires on every cnt wrap.

## Test plan
Bench parameters for all scenarios: DIGITS=4, PRESCALE=8, BLANK=2, ACTIVE_LOW=1.

1. Reset, then value=16'h1234, digit_en=4'hF, dp=0 held -> during the first 32 cycles an=4'b1111, seg=7'h7F, seg_dp=1; frame_start pulses once at cycle 32.
2. Second frame, same inputs:
   - slot 0: an=1111 for 2 cycles, then 1110 for 6 cycles with seg=~66=7'h19;
   - slot 1: seg=~4F=7'h30, an=1101;
   - slots 2 and 3: seg=~5B=7'h24, then ~06=7'h79.
3. Change value to 16'hABCD mid-frame -> the current frame still shows 4,3,2,1; the next frame shows D,C,B,A, i.e. seg 7'h21, 7'h46, 7'h03, 7'h08.
4. digit_en=4'b0101, dp=4'b0001 -> an[1] and an[3] never go low; seg_dp=0 only during the DRIVE phase of slot 0; seg=7'h7F during slots 1 and 3.
5. Sweep the nibble over 0..F on digit 0 across 16 frames -> seg matches the inverted decode table for every value; frame_start is period-32 throughout.
6. Pull resetn low at cycle 45 for 3 cycles -> outputs are all ones within the same cycle; after release, 32 dark cycles, then a frame_start pulse, then the display resumes with correct slot ordering.

Source files
------------

// File: rtl/io_seg7_scan.sv
// Seven-segment display scanner. It snapshots the digit values, decimal
// points and enables once per frame. It then shows one digit per slot, and
// each slot opens with a short all-dark blank so the previous digit does
// not ghost onto the next one. All pin outputs are registered.
module io_seg7_scan #(
  parameter int DIGITS     = 8,
  parameter int PRESCALE   = 50000,
  parameter int BLANK      = 64,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     digit_en,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_start
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic POL = (ACTIVE_LOW != 0);
  localparam logic [6:0]        SEG_OFF = {7{POL}};
  localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{POL}};

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] value_q;
  logic [DIGITS-1:0]   dp_q, en_q;
  logic [6:0]          seg_q, seg_d;
  logic                seg_dp_q, seg_dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                fs_q;
  logic                cnt_wrap, load, drive;
  logic [3:0]          nib;
  logic [6:0]          dec;

  assign cnt_wrap = (cnt_q == CNT_W'(PRESCALE - 1));
  assign load     = cnt_wrap && (idx_q == IDX_W'(DIGITS - 1));

  // Next slot position: cnt free-runs per slot, idx steps on each cnt wrap.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_wrap) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // Slot position registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // Frame snapshot. It is taken only on the last cycle of the last slot, so
  // a CPU write never tears a frame.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      value_q <= '0;
      dp_q    <= '0;
      en_q    <= '0;
    end else if (load) begin
      value_q <= value;
      dp_q    <= dp;
      en_q    <= digit_en;
    end
  end

  // Pick the current digit nibble and decode it to active-high segments a..g.
  always_comb begin
    nib = value_q[{idx_q, 2'b00} +: 4];
    dec = 7'h00;
    case (nib)
      4'h0: dec = 7'h3F;
      4'h1: dec = 7'h06;
      4'h2: dec = 7'h5B;
      4'h3: dec = 7'h4F;
      4'h4: dec = 7'h66;
      4'h5: dec = 7'h6D;
      4'h6: dec = 7'h7D;
      4'h7: dec = 7'h07;
      4'h8: dec = 7'h7F;
      4'h9: dec = 7'h6F;
      4'hA: dec = 7'h77;
      4'hB: dec = 7'h7C;
      4'hC: dec = 7'h39;
      4'hD: dec = 7'h5E;
      4'hE: dec = 7'h79;
      4'hF: dec = 7'h71;
      default: dec = 7'h00;
    endcase
  end

  // Build the pin values. Blank or disabled slots drive everything inactive.
  always_comb begin
    drive    = (cnt_q >= CNT_W'(BLANK)) && en_q[idx_q];
    seg_d    = SEG_OFF;
    seg_dp_d = POL;
    an_d     = '0;
    if (drive) begin
      an_d[idx_q] = 1'b1;
      seg_d       = dec ^ SEG_OFF;
      seg_dp_d    = dp_q[idx_q] ^ POL;
    end
    an_d = an_d ^ AN_OFF;
  end

  // Output registers. They go inactive on reset without waiting for a clock.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      seg_q    <= SEG_OFF;
      seg_dp_q <= POL;
      an_q     <= AN_OFF;
      fs_q     <= 1'b0;
    end else begin
      seg_q    <= seg_d;
      seg_dp_q <= seg_dp_d;
      an_q     <= an_d;
      fs_q     <= load;
    end
  end

  assign seg         = seg_q;
  assign seg_dp      = seg_dp_q;
  assign an          = an_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_io_seg7_scan.sv
// Testbench for io_seg7_scan with 4 digits, 8-cycle slots, a 2-cycle blank
// and active-low pins. Each frame's expected pin values come from a frame
// model of the snapshot the scanner should hold. They are queued up front
// and then popped and compared cycle by cycle.
module tb_io_seg7_scan;

  localparam int D  = 4;
  localparam int P  = 8;
  localparam int B  = 2;
  localparam int FR = D * P;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       fs;
  } exp_t;

  logic        clk;
  logic        resetn;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  digit_en;
  logic [6:0]  seg;
  logic        seg_dp;
  logic [3:0]  an;
  logic        frame_start;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  exp_t exp_q[$];
  logic [6:0] tab [16];

  logic        first;
  logic [15:0] shp_v, shc_v;
  logic [3:0]  shp_e, shc_e, shp_d, shc_d;

  io_seg7_scan #(
    .DIGITS(D), .PRESCALE(P), .BLANK(B), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .resetn(resetn), .value(value), .dp(dp), .digit_en(digit_en),
    .seg(seg), .seg_dp(seg_dp), .an(an), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp_v);
    end
  endtask

  function automatic exp_t slot_exp(input logic [15:0] v, input logic [3:0] e,
                                    input logic [3:0] d, input int c, input int i);
    exp_t x;
    logic [3:0] n;
    logic [3:0] oh;
    x = '{seg: 7'h7F, dp: 1'b1, an: 4'hF, fs: 1'b0};
    if (c >= B && e[i]) begin
      n  = v[4*i +: 4];
      oh = 4'b0001 << i;
      x.seg = ~tab[n];
      x.dp  = ~d[i];
      x.an  = ~oh;
    end
    return x;
  endfunction

  // Output window for one frame. Its first cycle still shows the final drive
  // cycle of the previous frame, or the reset state right after reset.
  task automatic push_window();
    exp_t x;
    for (int k = 0; k < FR; k++) begin
      if (k == 0) begin
        if (first) x = '{seg: 7'h7F, dp: 1'b1, an: 4'hF, fs: 1'b0};
        else begin
          x    = slot_exp(shp_v, shp_e, shp_d, P - 1, D - 1);
          x.fs = 1'b1;
        end
      end else begin
        x = slot_exp(shc_v, shc_e, shc_d, (k - 1) % P, (k - 1) / P);
      end
      exp_q.push_back(x);
    end
  endtask

  task automatic check_cycle();
    exp_t x;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 32'd1, 32'd0);
    end else begin
      x = exp_q.pop_front();
      chk("seg", 32'(seg), 32'(x.seg));
      chk("seg_dp", 32'(seg_dp), 32'(x.dp));
      chk("an", 32'(an), 32'(x.an));
      chk("frame_start", 32'(frame_start), 32'(x.fs));
    end
  endtask

  task automatic check_dark(input string tag);
    chk({tag, "_seg"}, 32'(seg), 32'h7F);
    chk({tag, "_dp"}, 32'(seg_dp), 32'h1);
    chk({tag, "_an"}, 32'(an), 32'hF);
    chk({tag, "_fs"}, 32'(frame_start), 32'h0);
  endtask

  // Run n cycles of one frame and apply new inputs at cycle chg_k. A full
  // frame then moves the model snapshot forward to the inputs now held.
  task automatic run_frame(input int n, input int chg_k, input logic [15:0] nv,
                           input logic [3:0] nen, input logic [3:0] ndp);
    push_window();
    for (int k = 0; k < n; k++) begin
      check_cycle();
      if (k == chg_k) begin
        value    = nv;
        digit_en = nen;
        dp       = ndp;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    if (n == FR) begin
      shp_v = shc_v; shp_e = shc_e; shp_d = shc_d;
      shc_v = value; shc_e = digit_en; shc_d = dp;
      first = 1'b0;
    end else begin
      exp_q.delete();
    end
  endtask

  task automatic model_reset();
    first = 1'b1;
    shp_v = '0; shp_e = '0; shp_d = '0;
    shc_v = '0; shc_e = '0; shc_d = '0;
    exp_q.delete();
    cyc = 0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_dark("in_reset");
    @(negedge clk);
    resetn = 1'b1;
    #1;
    model_reset();
  endtask

  initial begin
    tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    resetn   = 1'b0;
    value    = 16'h1234;
    digit_en = 4'hF;
    dp       = 4'h0;
    model_reset();

    do_reset();
    // Frame 0 is dark. Frame 1 shows 4,3,2,1 while ABCD arrives mid-frame.
    run_frame(FR, 0, 16'h1234, 4'hF, 4'h0);
    run_frame(FR, 12, 16'hABCD, 4'hF, 4'h0);
    // Frame 2 shows D,C,B,A. Partial enables and a DP are loaded for frame 3.
    run_frame(FR, 5, 16'hABCD, 4'b0101, 4'b0001);
    run_frame(FR, 31, 16'h0000, 4'hF, 4'h0);
    // Sweep digit 0 over every hex value, one value per frame.
    for (int n = 0; n < 16; n++)
      run_frame(FR, 3, {12'h000, 4'(n)}, 4'hF, 4'h0);
    run_frame(FR, 20, 16'h5678, 4'hF, 4'b0010);

    // Reset asserted mid-frame at cycle 45, held for 3 cycles.
    do_reset();
    run_frame(FR, 0, 16'h5678, 4'hF, 4'b0010);
    run_frame(13, 0, 16'h5678, 4'hF, 4'b0010);
    resetn = 1'b0;
    #1;
    check_dark("async_reset");
    repeat (3) begin
      @(posedge clk);
      #1;
      check_dark("held_reset");
    end
    @(negedge clk);
    resetn = 1'b1;
    #1;
    model_reset();
    run_frame(FR, 0, 16'h5678, 4'hF, 4'b0010);
    run_frame(FR, 0, 16'h5678, 4'hF, 4'b0010);
    run_frame(FR, 0, 16'h5678, 4'hF, 4'b0010);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
